// File: rtl/arc4_pkg.sv
// Shared types and default widths for the ARC4 sequencer and its s_mem port mux.
package arc4_pkg;

    localparam int KEY_W   = 24;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 4096;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_INIT = 2'd1,
        PH_KSA  = 2'd2,
        PH_PRGA = 2'd3
    } phase_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_REQ, ST_INIT_GAP, ST_INIT_WAIT,
        ST_KSA_REQ,  ST_KSA_GAP,  ST_KSA_WAIT,
        ST_PRGA_REQ, ST_PRGA_GAP, ST_PRGA_WAIT,
        ST_ERR
    } state_t;

    // The s_mem owner is a pure function of the sequencer state.
    function automatic phase_t state_phase(input state_t s);
        case (s)
            ST_INIT_REQ, ST_INIT_GAP, ST_INIT_WAIT: return PH_INIT;
            ST_KSA_REQ,  ST_KSA_GAP,  ST_KSA_WAIT:  return PH_KSA;
            ST_PRGA_REQ, ST_PRGA_GAP, ST_PRGA_WAIT: return PH_PRGA;
            default:                                return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/arc4_sched_if.sv
// Bundle of the sequencer's control, client handshake and s_mem port signals.
interface arc4_sched_if #(
    parameter int KEY_W  = arc4_pkg::KEY_W,
    parameter int ADDR_W = arc4_pkg::ADDR_W,
    parameter int DATA_W = arc4_pkg::DATA_W
);
    logic              en;
    logic              rdy;
    logic              err;
    logic [KEY_W-1:0]  key;
    logic [KEY_W-1:0]  key_out;

    logic              init_en, ksa_en, prga_en;
    logic              init_rdy, ksa_rdy, prga_rdy;

    logic [ADDR_W-1:0] init_addr, ksa_addr, prga_addr;
    logic [DATA_W-1:0] init_wrdata, ksa_wrdata, prga_wrdata;
    logic              init_wren, ksa_wren, prga_wren;

    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wrdata;
    logic              s_wren;

    arc4_pkg::phase_t  phase;

    modport slave (
        input  en, key,
        input  init_rdy, ksa_rdy, prga_rdy,
        input  init_addr, ksa_addr, prga_addr,
        input  init_wrdata, ksa_wrdata, prga_wrdata,
        input  init_wren, ksa_wren, prga_wren,
        output rdy, err, key_out,
        output init_en, ksa_en, prga_en,
        output s_addr, s_wrdata, s_wren, phase
    );

    modport master (
        output en, key,
        output init_rdy, ksa_rdy, prga_rdy,
        output init_addr, ksa_addr, prga_addr,
        output init_wrdata, ksa_wrdata, prga_wrdata,
        output init_wren, ksa_wren, prga_wren,
        input  rdy, err, key_out,
        input  init_en, ksa_en, prga_en,
        input  s_addr, s_wrdata, s_wren, phase
    );

endinterface

// File: rtl/arc4_mem_mux.sv
// Combinational 3:1 s_mem port mux; the current owner passes straight through, no owner gives zeros.
module arc4_mem_mux
    import arc4_pkg::*;
#(
    parameter int ADDR_W = arc4_pkg::ADDR_W,
    parameter int DATA_W = arc4_pkg::DATA_W
) (
    input  phase_t            phase_i,
    input  logic [ADDR_W-1:0] init_addr_i,
    input  logic [ADDR_W-1:0] ksa_addr_i,
    input  logic [ADDR_W-1:0] prga_addr_i,
    input  logic [DATA_W-1:0] init_wrdata_i,
    input  logic [DATA_W-1:0] ksa_wrdata_i,
    input  logic [DATA_W-1:0] prga_wrdata_i,
    input  logic              init_wren_i,
    input  logic              ksa_wren_i,
    input  logic              prga_wren_i,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wrdata_o,
    output logic              s_wren_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        s_addr_o   = '0;
        s_wrdata_o = '0;
        s_wren_o   = 1'b0;
        case (phase_i)
            PH_INIT: begin
                s_addr_o   = init_addr_i;
                s_wrdata_o = init_wrdata_i;
                s_wren_o   = init_wren_i;
            end
            PH_KSA: begin
                s_addr_o   = ksa_addr_i;
                s_wrdata_o = ksa_wrdata_i;
                s_wren_o   = ksa_wren_i;
            end
            PH_PRGA: begin
                s_addr_o   = prga_addr_i;
                s_wrdata_o = prga_wrdata_i;
                s_wren_o   = prga_wren_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 top-level sequencer: runs init -> ksa -> prga per request and arbitrates the single s_mem port.
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int KEY_W   = arc4_pkg::KEY_W,
    parameter int ADDR_W  = arc4_pkg::ADDR_W,
    parameter int DATA_W  = arc4_pkg::DATA_W,
    parameter int TIMEOUT = arc4_pkg::TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    arc4_sched_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             init_en_q, init_en_d;
    logic             ksa_en_q, ksa_en_d;
    logic             prga_en_q, prga_en_d;
    logic             rdy_q, err_q;
    phase_t           phase;
    logic             timeout;

    assign phase   = state_phase(state_q);
    assign timeout = (phase != PH_NONE) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        cnt_d     = (phase != PH_NONE) ? cnt_q + 1'b1 : cnt_q;
        init_en_d = 1'b0;
        ksa_en_d  = 1'b0;
        prga_en_d = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.en) begin
                key_d   = bus.key;
                cnt_d   = '0;
                state_d = ST_INIT_REQ;
            end
            ST_INIT_REQ: if (bus.init_rdy) begin
                init_en_d = 1'b1;
                state_d   = ST_INIT_GAP;
            end
            ST_INIT_GAP:  state_d = ST_INIT_WAIT;
            ST_INIT_WAIT: if (bus.init_rdy) begin
                cnt_d   = '0;
                state_d = ST_KSA_REQ;
            end
            ST_KSA_REQ: if (bus.ksa_rdy) begin
                ksa_en_d = 1'b1;
                state_d  = ST_KSA_GAP;
            end
            ST_KSA_GAP:  state_d = ST_KSA_WAIT;
            ST_KSA_WAIT: if (bus.ksa_rdy) begin
                cnt_d   = '0;
                state_d = ST_PRGA_REQ;
            end
            ST_PRGA_REQ: if (bus.prga_rdy) begin
                prga_en_d = 1'b1;
                state_d   = ST_PRGA_GAP;
            end
            ST_PRGA_GAP:  state_d = ST_PRGA_WAIT;
            ST_PRGA_WAIT: if (bus.prga_rdy) state_d = ST_IDLE;
            ST_ERR:       ;
            default:      state_d = ST_IDLE;
        endcase

        // A stuck client overrides any handshake progress in the same cycle.
        if (timeout) begin
            state_d   = ST_ERR;
            init_en_d = 1'b0;
            ksa_en_d  = 1'b0;
            prga_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            key_q     <= '0;
            init_en_q <= 1'b0;
            ksa_en_q  <= 1'b0;
            prga_en_q <= 1'b0;
            rdy_q     <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            init_en_q <= init_en_d;
            ksa_en_q  <= ksa_en_d;
            prga_en_q <= prga_en_d;
            rdy_q     <= (state_d == ST_IDLE);
            err_q     <= (state_d == ST_ERR);
        end
    end

    assign bus.rdy     = rdy_q;
    assign bus.err     = err_q;
    assign bus.key_out = key_q;
    assign bus.init_en = init_en_q;
    assign bus.ksa_en  = ksa_en_q;
    assign bus.prga_en = prga_en_q;
    assign bus.phase   = phase;

    arc4_mem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_mux (
        .phase_i       (phase),
        .init_addr_i   (bus.init_addr),
        .ksa_addr_i    (bus.ksa_addr),
        .prga_addr_i   (bus.prga_addr),
        .init_wrdata_i (bus.init_wrdata),
        .ksa_wrdata_i  (bus.ksa_wrdata),
        .prga_wrdata_i (bus.prga_wrdata),
        .init_wren_i   (bus.init_wren),
        .ksa_wren_i    (bus.ksa_wren),
        .prga_wren_i   (bus.prga_wren),
        .s_addr_o      (bus.s_addr),
        .s_wrdata_o    (bus.s_wrdata),
        .s_wren_o      (bus.s_wren)
    );

endmodule

// File: tb/tb_arc4_sched.sv
// Randomized scoreboard bench for arc4_sched: stub clients, a stage-level reference model and a timeout DUT.
module tb_arc4_sched;
    import arc4_pkg::*;

    localparam int TO_B  = 64;
    localparam int NEVER = -1;

    typedef struct {
        logic             rdy;
        logic             err;
        logic [2:0]       en;
        phase_t           phase;
        logic [KEY_W-1:0] key_out;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_checks = 0;
    int   n_pass   = 0;

    arc4_sched_if bus_a ();
    arc4_sched_if bus_b ();

    arc4_sched #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT))
        dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
    arc4_sched #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO_B))
        dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));

    always #5 clk = ~clk;

    // Client stub state, indexed [dut][client], client 0=init 1=ksa 2=prga.
    bit                c_idle [2][3];
    bit                hold   [2][3];
    int                busy   [2][3];
    int                left   [2][3];
    logic [DATA_W-1:0] c_wd   [2][3];
    logic              c_wr   [2][3];
    logic [2:0]        cen    [2];

    function automatic logic [ADDR_W-1:0] c_addr(input int i);
        return ADDR_W'(17 * (i + 1));
    endfunction

    function automatic logic c_rdy(input int d, input int i);
        return c_idle[d][i] && !hold[d][i];
    endfunction

    assign bus_a.init_rdy    = c_rdy(0, 0);
    assign bus_a.ksa_rdy     = c_rdy(0, 1);
    assign bus_a.prga_rdy    = c_rdy(0, 2);
    assign bus_a.init_addr   = c_addr(0);
    assign bus_a.ksa_addr    = c_addr(1);
    assign bus_a.prga_addr   = c_addr(2);
    assign bus_a.init_wrdata = c_wd[0][0];
    assign bus_a.ksa_wrdata  = c_wd[0][1];
    assign bus_a.prga_wrdata = c_wd[0][2];
    assign bus_a.init_wren   = c_wr[0][0];
    assign bus_a.ksa_wren    = c_wr[0][1];
    assign bus_a.prga_wren   = c_wr[0][2];
    assign cen[0]            = {bus_a.prga_en, bus_a.ksa_en, bus_a.init_en};

    assign bus_b.init_rdy    = c_rdy(1, 0);
    assign bus_b.ksa_rdy     = c_rdy(1, 1);
    assign bus_b.prga_rdy    = c_rdy(1, 2);
    assign bus_b.init_addr   = c_addr(0);
    assign bus_b.ksa_addr    = c_addr(1);
    assign bus_b.prga_addr   = c_addr(2);
    assign bus_b.init_wrdata = c_wd[1][0];
    assign bus_b.ksa_wrdata  = c_wd[1][1];
    assign bus_b.prga_wrdata = c_wd[1][2];
    assign bus_b.init_wren   = c_wr[1][0];
    assign bus_b.ksa_wren    = c_wr[1][1];
    assign bus_b.prga_wren   = c_wr[1][2];
    assign cen[1]            = {bus_b.prga_en, bus_b.ksa_en, bus_b.init_en};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Stub clients: drop rdy when started, come back after busy[] cycles (never for NEVER).
    initial begin : stubs
        logic [1:0] r;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 3; i++) begin
                c_idle[d][i] = 1'b1;
                left[d][i]   = 0;
                c_wd[d][i]   = '0;
                c_wr[d][i]   = 1'b0;
            end
        forever begin
            @(posedge clk);
            r = {rst_b, rst_a};
            #1;
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 3; i++) begin
                    if (r[d]) begin
                        c_idle[d][i] = 1'b1;
                        left[d][i]   = 0;
                    end else if (cen[d][i]) begin
                        c_idle[d][i] = 1'b0;
                        left[d][i]   = busy[d][i];
                    end else if (left[d][i] > 0) begin
                        left[d][i]--;
                        if (left[d][i] == 0) c_idle[d][i] = 1'b1;
                    end
                    c_wd[d][i] = DATA_W'($urandom);
                    c_wr[d][i] = 1'($urandom);
                end
        end
    end

    // Reference model for dut_a: stage 0 idle, 1..3 = client, 4 = error; step 0 req, 1 gap, 2 wait.
    int               m_stage = 0;
    int               m_step  = 0;
    int               m_cnt   = 0;
    logic [KEY_W-1:0] m_key;
    exp_t             exp_q[$];
    int               pulse_q[$];
    int               ksa_en_cycles = 0;

    initial begin : model_a
        exp_t       e;
        logic [2:0] pulse;
        int         c;
        forever begin
            @(posedge clk);
            pulse = '0;
            if (rst_a) begin
                m_stage = 0; m_step = 0; m_cnt = 0; m_key = '0;
                pulse_q.delete();
            end else if (m_stage == 0) begin
                if (bus_a.en) begin
                    m_key = bus_a.key; m_stage = 1; m_step = 0; m_cnt = 0;
                    pulse_q.push_back(0); pulse_q.push_back(1); pulse_q.push_back(2);
                end
            end else if (m_stage <= 3) begin
                c = m_stage - 1;
                m_cnt++;
                if (m_cnt == TIMEOUT) m_stage = 4;
                else if (m_step == 0) begin
                    if (c_rdy(0, c)) begin pulse[c] = 1'b1; m_step = 1; end
                end else if (m_step == 1) m_step = 2;
                else if (c_rdy(0, c)) begin
                    m_step = 0; m_cnt = 0;
                    m_stage = (m_stage == 3) ? 0 : m_stage + 1;
                end
            end
            e.rdy     = (m_stage == 0);
            e.err     = (m_stage == 4);
            e.en      = pulse;
            e.phase   = (m_stage >= 1 && m_stage <= 3) ? phase_t'(m_stage) : PH_NONE;
            e.key_out = m_key;
            exp_q.push_back(e);
        end
    end

    initial begin : monitor_a
        exp_t              e;
        int                o;
        int                p;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic              ew;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rdy", bus_a.rdy, e.rdy);
                check("err", bus_a.err, e.err);
                check("client_en", cen[0], e.en);
                check("phase", bus_a.phase, e.phase);
                check("key_out", bus_a.key_out, e.key_out);
                o = int'(e.phase);
                if (o == 0) begin
                    ea = '0; ed = '0; ew = 1'b0;
                end else begin
                    ea = c_addr(o - 1); ed = c_wd[0][o - 1]; ew = c_wr[0][o - 1];
                end
                check("s_addr", bus_a.s_addr, ea);
                check("s_wrdata", bus_a.s_wrdata, ed);
                check("s_wren", bus_a.s_wren, ew);
                for (int i = 0; i < 3; i++)
                    if (cen[0][i]) begin
                        if (i == 1) ksa_en_cycles++;
                        p = (pulse_q.size() > 0) ? pulse_q.pop_front() : -1;
                        check("en_order", i, p);
                    end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rdy_a(input string name, input int budget);
        int n = 0;
        while (bus_a.rdy !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, bus_a.rdy, 1'b1);
    endtask

    task automatic wait_phase_a(input string name, input phase_t ph, input int budget);
        int n = 0;
        while (bus_a.phase !== ph && n < budget) begin
            tick(1);
            n++;
        end
        check(name, bus_a.phase, ph);
    endtask

    task automatic start_a(input logic [KEY_W-1:0] k);
        bus_a.key = k;
        bus_a.en  = 1'b1;
        tick(1);
        bus_a.en  = 1'b0;
        bus_a.key = KEY_W'($urandom);
    endtask

    initial begin : stimulus
        int n;
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.en = 1'b0; bus_a.key = '0;
        bus_b.en = 1'b0; bus_b.key = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 3; i++) begin
                hold[d][i] = 1'b0;
                busy[d][i] = 4;
            end
        busy[1][2] = NEVER;
        tick(3);
        check("reset_rdy", bus_a.rdy, 1'b1);
        check("reset_err", bus_a.err, 1'b0);
        check("reset_key_out", bus_a.key_out, '0);
        check("reset_phase", bus_a.phase, PH_NONE);
        check("reset_en", cen[0], 3'b000);
        rst_a = 1'b0; rst_b = 1'b0;
        tick(2);

        // Nominal run with long client busy times; key changes after acceptance.
        busy[0][0] = 256; busy[0][1] = 768; busy[0][2] = 512;
        start_a(24'h00033C);
        check("run1_rdy_drop", bus_a.rdy, 1'b0);
        wait_rdy_a("run1_done", 3000);
        check("run1_key_out", bus_a.key_out, 24'h00033C);
        check("run1_pulses", pulse_q.size(), 0);
        check("idle_s_addr", bus_a.s_addr, '0);

        // en held through a run is ignored; still high when rdy returns -> back-to-back run.
        bus_a.key = 24'h00033C;
        bus_a.en  = 1'b1;
        tick(1);
        wait_rdy_a("run2a_done", 3000);
        tick(1);
        bus_a.en = 1'b0;
        check("b2b_start", bus_a.rdy, 1'b0);
        wait_rdy_a("run2b_done", 3000);

        // ksa_rdy held low for 10 cycles at KSA_REQ.
        busy[0][0] = 20; busy[0][1] = 30; busy[0][2] = 20;
        ksa_en_cycles = 0;
        hold[0][1] = 1'b1;
        start_a(KEY_W'($urandom));
        wait_phase_a("ksa_reached", PH_KSA, 200);
        tick(10);
        check("ksa_en_held", ksa_en_cycles, 0);
        hold[0][1] = 1'b0;
        wait_rdy_a("run3_done", 500);
        check("ksa_en_once", ksa_en_cycles, 1);

        // Reset in the middle of KSA_WAIT.
        start_a(24'hABCDEF);
        wait_phase_a("ksa_reached2", PH_KSA, 200);
        tick(10);
        rst_a = 1'b1;
        tick(1);
        rst_a = 1'b0;
        check("midrst_rdy", bus_a.rdy, 1'b1);
        check("midrst_phase", bus_a.phase, PH_NONE);
        check("midrst_s_wren", bus_a.s_wren, 1'b0);
        check("midrst_key_out", bus_a.key_out, '0);
        tick(2);

        // Randomized runs with stray en pulses during the run.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 3; i++) busy[0][i] = $urandom_range(1, 30);
            start_a(KEY_W'($urandom));
            tick($urandom_range(1, 40));
            bus_a.en = 1'b1;
            tick(1);
            bus_a.en = 1'b0;
            wait_rdy_a("rand_done", 500);
            tick($urandom_range(0, 3));
        end
        wait_rdy_a("final_idle", 500);
        tick(2);
        check("pulse_leftover", pulse_q.size(), 0);

        // Timeout DUT: prga never returns rdy; err exactly TO_B cycles after PRGA_REQ entry.
        bus_b.en = 1'b1;
        tick(1);
        bus_b.en = 1'b0;
        n = 0;
        while (bus_b.phase !== PH_PRGA && n < 200) begin
            tick(1);
            n++;
        end
        check("to_prga_reached", bus_b.phase, PH_PRGA);
        tick(TO_B - 1);
        check("to_err_early", bus_b.err, 1'b0);
        tick(1);
        check("to_err", bus_b.err, 1'b1);
        check("to_rdy", bus_b.rdy, 1'b0);
        check("to_s_wren", bus_b.s_wren, 1'b0);
        check("to_prga_en", bus_b.prga_en, 1'b0);
        bus_b.en = 1'b1;
        tick(5);
        bus_b.en = 1'b0;
        check("to_en_ignored_err", bus_b.err, 1'b1);
        check("to_en_ignored_phase", bus_b.phase, PH_NONE);
        check("to_en_ignored_init", bus_b.init_en, 1'b0);
        rst_b = 1'b1;
        tick(1);
        rst_b = 1'b0;
        check("to_rst_err", bus_b.err, 1'b0);
        check("to_rst_rdy", bus_b.rdy, 1'b1);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
